// File: rtl/tinylab_pkg.sv
// tinylab_pkg: shared types and widths for the tinylabcpu memory blocks.
//   mem_state_t : responder FSM state (IDLE, WAIT, RESP)
//   INS_W       : instruction word width
//   ADDR_W      : fetch/load address width
//   LAT_CNT_W   : width of the access-latency down-counter
package tinylab_pkg;

  localparam int INS_W     = 16;
  localparam int ADDR_W    = 16;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/ins_mem_array.sv
// ins_mem_array: DEPTH x INS_W program store, block-RAM style.
//   clk, rst     : clock, synchronous active-low reset (read register only)
//   we, wa, wd   : synchronous write port
//   re, ra       : synchronous read port enable/address
//   rd           : registered read data, holds while re=0
// A read and a write to the same word on one edge return the old word.
import tinylab_pkg::*;

module ins_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [INS_W-1:0] wd,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [INS_W-1:0] rd
);

  logic [INS_W-1:0] r_mem [DEPTH];

  // Storage is never reset so it stays a plain RAM.
  always_ff @(posedge clk) begin
    if (we) r_mem[wa] <= wd;
  end

  // Output register doubles as the response register; nonblocking
  // semantics give read-before-write against the write block above.
  always_ff @(posedge clk) begin
    if (!rst)    rd <= '0;
    else if (re) rd <= r_mem[ra];
  end

endmodule

// File: rtl/ins_mem_resp.sv
// ins_mem_resp: instruction-memory responder for the tinylabcpu fetch port.
//   clk, rst            : clock, synchronous active-low reset
//   en_ram_in, addr     : fetch request strobe and word address
//   ins, en_ram_out     : response word and one-cycle response strobe
//   ld_en/ld_addr/ld_data : program-image load port (any state)
//   busy                : request outstanding (WAIT)
//   addr_err            : sticky out-of-range fetch/load flag
// The array is read at request acceptance, so later loads to the in-flight
// address cannot change the pending response.
import tinylab_pkg::*;

module ins_mem_resp #(
  parameter int               DEPTH     = 256,
  parameter int               LATENCY   = 2,
  parameter logic [INS_W-1:0] INIT_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ram_in,
  input  logic [ADDR_W-1:0] addr,
  output logic [INS_W-1:0]  ins,
  output logic              en_ram_out,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [INS_W-1:0]  ld_data,
  output logic              busy,
  output logic              addr_err
);

  localparam int AW = $clog2(DEPTH);

  mem_state_t           r_state, w_state_nxt;
  logic [LAT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                 r_oor;
  logic                 r_addr_err;
  logic                 w_accept;
  logic                 w_fetch_oor;
  logic                 w_ld_oor;
  logic [INS_W-1:0]     w_rd_data;

  // Full-width compare so addresses aliasing onto the index bits are caught.
  assign w_fetch_oor = (32'(addr)    >= 32'(DEPTH));
  assign w_ld_oor    = (32'(ld_addr) >= 32'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        if (en_ram_in) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = LAT_CNT_W'(LATENCY - 1);
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        // Requests arriving here are dropped, not queued.
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= 1) w_state_nxt = RESP;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_oor      <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) r_oor <= w_fetch_oor;
      if ((w_accept && w_fetch_oor) || (ld_en && w_ld_oor)) r_addr_err <= 1'b1;
    end
  end

  ins_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk (clk),
    .rst (rst),
    .we  (ld_en && !w_ld_oor),
    .wa  (ld_addr[AW-1:0]),
    .wd  (ld_data),
    .re  (w_accept && !w_fetch_oor),
    .ra  (addr[AW-1:0]),
    .rd  (w_rd_data)
  );

  // Decodes of registers only: no input-to-output combinational path.
  assign ins        = r_oor ? INIT_WORD : w_rd_data;
  assign en_ram_out = (r_state == RESP);
  assign busy       = (r_state == WAIT);
  assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_ins_mem_resp.sv
// tb_ins_mem_resp: directed bench for ins_mem_resp. Four instances (LATENCY
// 1..4) share all inputs; each scenario checks the instance it targets.
module tb_ins_mem_resp;

  logic        clk = 1'b0;
  logic        rst, en_ram_in, ld_en;
  logic [15:0] addr, ld_addr, ld_data;

  logic [15:0] ins1, ins2, ins3, ins4;
  logic        eo1, eo2, eo3, eo4;
  logic        bz1, bz2, bz3, bz4;
  logic        ae1, ae2, ae3, ae4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ins_mem_resp #(.DEPTH(256), .LATENCY(1), .INIT_WORD(16'hDEAD)) u_l1 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr), .ins(ins1),
    .en_ram_out(eo1), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(bz1), .addr_err(ae1));
  ins_mem_resp #(.DEPTH(256), .LATENCY(2), .INIT_WORD(16'hDEAD)) u_l2 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr), .ins(ins2),
    .en_ram_out(eo2), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(bz2), .addr_err(ae2));
  ins_mem_resp #(.DEPTH(256), .LATENCY(3), .INIT_WORD(16'hDEAD)) u_l3 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr), .ins(ins3),
    .en_ram_out(eo3), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(bz3), .addr_err(ae3));
  ins_mem_resp #(.DEPTH(256), .LATENCY(4), .INIT_WORD(16'hDEAD)) u_l4 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr), .ins(ins4),
    .en_ram_out(eo4), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(bz4), .addr_err(ae4));

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en_ram_in = 1'b0; ld_en = 1'b0;
    addr = '0; ld_addr = '0; ld_data = '0;
    drain(2);
    tests++; if (eo2 !== 1'b0)     begin fails++; $display("FAIL rst_en_out: got %b expected 0", eo2); end
    tests++; if (ins2 !== 16'h0)   begin fails++; $display("FAIL rst_ins: got %h expected 0000", ins2); end
    tests++; if (bz2 !== 1'b0)     begin fails++; $display("FAIL rst_busy: got %b expected 0", bz2); end
    tests++; if (ae2 !== 1'b0)     begin fails++; $display("FAIL rst_addr_err: got %b expected 0", ae2); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_lat2();
    load(16'h0010, 16'hA5C3);
    en_ram_in = 1'b1; addr = 16'h0010;
    tick();                               // request edge t
    en_ram_in = 1'b0;
    tests++; if (bz2 !== 1'b1 || eo2 !== 1'b0) begin fails++; $display("FAIL lat2_wait: busy %b en_out %b expected 1 0", bz2, eo2); end
    tick();                               // edge t+1
    tests++; if (eo2 !== 1'b1)     begin fails++; $display("FAIL lat2_en_out: got %b expected 1", eo2); end
    tests++; if (ins2 !== 16'hA5C3) begin fails++; $display("FAIL lat2_ins: got %h expected a5c3", ins2); end
    tests++; if (bz2 !== 1'b0)     begin fails++; $display("FAIL lat2_busy_resp: got %b expected 0", bz2); end
    tick();                               // strobe gone, word held
    tests++; if (eo2 !== 1'b0 || ins2 !== 16'hA5C3) begin fails++; $display("FAIL lat2_hold: en_out %b ins %h expected 0 a5c3", eo2, ins2); end
    drain(6);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) load(16'(i), 16'(i * 3));
    for (int i = 0; i < 8; i++) begin
      en_ram_in = 1'b1; addr = 16'(i);
      tick();
      tests++;
      if (eo1 !== 1'b1 || ins1 !== 16'(i * 3)) begin
        fails++; $display("FAIL b2b_%0d: en_out %b ins %h expected 1 %h", i, eo1, ins1, 16'(i * 3));
      end
    end
    en_ram_in = 1'b0;
    tick();
    tests++; if (eo1 !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b expected 0", eo1); end
    drain(6);
  endtask

  task automatic test_drop();
    int pulses = 0;
    int first_k = -1;
    logic [15:0] got = '0;
    en_ram_in = 1'b1; addr = 16'h0010;
    tick();                               // k=0: accepted
    if (eo3) begin pulses++; first_k = 0; got = ins3; end
    en_ram_in = 1'b1; addr = 16'h0003;    // arrives during WAIT
    tick();
    en_ram_in = 1'b0;
    if (eo3) begin pulses++; if (first_k < 0) begin first_k = 1; got = ins3; end end
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (eo3) begin pulses++; if (first_k < 0) begin first_k = k; got = ins3; end end
    end
    tests++; if (pulses !== 1)     begin fails++; $display("FAIL drop_count: got %0d expected 1", pulses); end
    tests++; if (first_k !== 2)    begin fails++; $display("FAIL drop_cycle: got %0d expected 2", first_k); end
    tests++; if (got !== 16'hA5C3) begin fails++; $display("FAIL drop_ins: got %h expected a5c3", got); end
    drain(4);
  endtask

  task automatic test_out_of_range();
    en_ram_in = 1'b1; addr = 16'h0100;
    tick();
    en_ram_in = 1'b0;
    tick();
    tests++; if (eo2 !== 1'b1 || ins2 !== 16'hDEAD) begin fails++; $display("FAIL oor_resp: en_out %b ins %h expected 1 dead", eo2, ins2); end
    tests++; if (ae2 !== 1'b1) begin fails++; $display("FAIL oor_err: got %b expected 1", ae2); end
    drain(6);
    tests++; if (ae2 !== 1'b1) begin fails++; $display("FAIL oor_sticky: got %b expected 1", ae2); end
    load(16'h0200, 16'hBEEF);
    drain(1);
    en_ram_in = 1'b1; addr = 16'h0000;
    tick();
    en_ram_in = 1'b0;
    tick();
    tests++; if (eo2 !== 1'b1 || ins2 !== 16'h0000) begin fails++; $display("FAIL oor_load: en_out %b ins %h expected 1 0000", eo2, ins2); end
    drain(6);
  endtask

  task automatic test_rbw();
    load(16'h0005, 16'h2222);
    ld_en = 1'b1; ld_addr = 16'h0005; ld_data = 16'h1111;
    en_ram_in = 1'b1; addr = 16'h0005;
    tick();
    ld_en = 1'b0; en_ram_in = 1'b0;
    tick();
    tests++; if (eo2 !== 1'b1 || ins2 !== 16'h2222) begin fails++; $display("FAIL rbw_old: en_out %b ins %h expected 1 2222", eo2, ins2); end
    drain(6);
    en_ram_in = 1'b1; addr = 16'h0005;
    tick();
    en_ram_in = 1'b0;
    tick();
    tests++; if (eo2 !== 1'b1 || ins2 !== 16'h1111) begin fails++; $display("FAIL rbw_new: en_out %b ins %h expected 1 1111", eo2, ins2); end
    drain(6);
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    en_ram_in = 1'b1; addr = 16'h0010;
    tick();
    en_ram_in = 1'b0;
    tick();
    tests++; if (bz4 !== 1'b1) begin fails++; $display("FAIL rstmid_busy: got %b expected 1", bz4); end
    rst = 1'b0;
    tick();
    tests++;
    if (eo4 !== 1'b0 || ins4 !== 16'h0 || bz4 !== 1'b0 || ae4 !== 1'b0) begin
      fails++; $display("FAIL rstmid_vals: en_out %b ins %h busy %b err %b expected 0 0000 0 0", eo4, ins4, bz4, ae4);
    end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (eo4) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL rstmid_noresp: got %0d strobes expected 0", pulses); end
    tests++; if (ins4 !== 16'h0) begin fails++; $display("FAIL rstmid_ins: got %h expected 0000", ins4); end
  endtask

  initial begin
    test_reset();
    test_lat2();
    test_back_to_back();
    test_drop();
    test_out_of_range();
    test_rbw();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ins_mem_resp.md
# ins_mem_resp

Instruction-memory responder for the tinylabcpu fetch interface. It answers the CPU's fetch requests: it samples `en_ram_in`/`addr`, waits a programmable access latency, then returns the 16-bit instruction word on `ins` with a one-cycle `en_ram_out` strobe. A side load port lets a loader or testbench write the program image. It sits between `cpu` and the board-level program store, and it replaces the behavioural ROM in system simulation.

## Interface
Parameters:
- `DEPTH`, 256: number of 16-bit words; power of two, 2..65536.
- `LATENCY`, 2: cycles from request sample to `en_ram_out`; range 1..15.
- `INIT_WORD`, 16'h0000: word returned for out-of-range addresses.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low (asserted when 0, sampled on `clk` rising edge).
- `en_ram_in` in 1: fetch request strobe from the CPU.
- `addr` in 16: fetch word address, sampled with `en_ram_in`.
- `ins` out 16: instruction word; valid when `en_ram_out`=1, holds its value otherwise.
- `en_ram_out` out 1: response strobe, exactly one cycle per accepted request.
- `ld_en` in 1: load-port write enable.
- `ld_addr` in 16: load-port word address.
- `ld_data` in 16: load-port write data.
- `busy` out 1: high while a request is outstanding (WAIT state).
- `addr_err` out 1: sticky; set by any out-of-range fetch or load; cleared only by reset.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `en_ram_in`=1 → accept. Latch `addr` and read the array into the response register. Go to RESP if LATENCY=1, else WAIT with `cnt`=LATENCY-1.
- WAIT: decrement `cnt` each cycle. When `cnt` reaches 1, go to RESP. `en_ram_in` is ignored (dropped, not queued).
- RESP: `en_ram_out`=1 and `ins`=response register.
  - If `en_ram_in`=1 in this cycle, it is accepted as in IDLE. This allows back-to-back fetches at one per LATENCY cycles.
  - Otherwise go to IDLE.
- Out-of-range fetch (`addr` ≥ DEPTH): respond normally with `INIT_WORD` and set `addr_err`.
- Load port:
  - `ld_en`=1 writes `ld_data` to `ld_addr` in any state.
  - Out-of-range load: write suppressed, `addr_err` set.
- Same-cycle load write and fetch acceptance to the same address: the fetch returns the OLD word (read-before-write).
- A write landing during WAIT to the in-flight address does not change the pending response.
- Address compare uses the full 16 bits; array index is `addr[$clog2(DEPTH)-1:0]`.

## Timing
- Reset values: `en_ram_out`=0, `ins`=16'h0000, `busy`=0, `addr_err`=0, state IDLE, `cnt`=0. Array contents are not reset.
- Request sampled at edge t → `en_ram_out`=1 during the cycle after edge t+LATENCY-1. LATENCY=1 gives the response in the cycle right after the request edge.
- `busy`=1 exactly in WAIT, so it is never high when LATENCY=1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-request: the pending response is discarded and no `en_ram_out` follows. `addr_err` is cleared.
- Load writes take effect at the edge; a fetch accepted on a later edge sees the new data.

## Structure
- Shared package `tinylab_pkg`:
  - state enum `mem_state_t` {IDLE, WAIT, RESP};
  - constants `INS_W`=16, `ADDR_W`=16, `LAT_CNT_W`=4.
- Sub-module `ins_mem_array`: DEPTH×16 storage.
  - One synchronous write port.
  - One synchronous read port with read-before-write.
  - Maps to block RAM.
- Top file holds the FSM, latency counter, range check and `addr_err`.

## Test plan
- LATENCY=2: load 16'hA5C3 at 0x0010, fetch 0x0010 → `en_ram_out` is one cycle high 2 cycles after the request edge, `ins`=16'hA5C3, and `busy` is high for 1 cycle.
- LATENCY=1: 8 back-to-back fetches 0..7, with words preloaded as addr×3 → responses arrive every cycle in order with values 0, 3, 6, …, 21.
- LATENCY=3: request, then `en_ram_in` asserted during WAIT → that request is dropped, and exactly one `en_ram_out` is produced.
- DEPTH=256: fetch 0x0100 → `ins`=INIT_WORD and `addr_err`=1 stays set. A load to 0x0200 leaves word 0x0000 unchanged.
- Same-cycle load 16'h1111→0x0005 (old value 16'h2222) and fetch 0x0005 → returns 16'h2222; the next fetch returns 16'h1111.
- `rst`=0 during WAIT (LATENCY=4) → no `en_ram_out` ever appears, and all outputs are at their reset values on the next cycle.
